fifo_umbral: RTL and testbench

- Synchronous FIFO with programmable almost-full / almost-empty thresholds.
- It produces the FIFO status flags, the read/write strobes and the threshold-programmed indication consumed by the flow-control state machine.
- It sits on the data path between the producing and consuming logic; the state machine only observes its outputs.

---
 rtl/fifo_umbral.sv | 175 +++++++++++++++++
 tb/tb_fifo_umbral.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_umbral.sv
// fifo_umbral: synchronous FIFO with programmable almost-full / almost-empty
// thresholds, registered read data and one-cycle event pulses.
//
// Optional feature macro: FIFO_ERR_STICKY_EN
//   defined   -> o_err_sticky latches any overflow/underflow until reset
//   undefined -> o_err_sticky is tied to 0
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst_n          asynchronous active-low reset
//   i_push           write request
//   i_data_in        write data, sampled when the push is accepted
//   i_pop            read request
//   i_umbral_load    threshold load request
//   i_umbral_af_in   almost-full threshold value
//   i_umbral_ae_in   almost-empty threshold value
//   o_data_out       registered read data (holds when nothing is popped)
//   o_data_valid     o_data_out holds a word popped last cycle
//   o_fifo_full      count == DEPTH
//   o_fifo_empty     count == 0
//   o_fifo_write     pulse: push accepted last cycle
//   o_fifo_read      pulse: pop accepted last cycle
//   o_almost_full    count >= af threshold
//   o_almost_empty   count <= ae threshold
//   o_umbral_set     a valid threshold pair has been loaded since reset
//   o_overflow       pulse: push rejected last cycle
//   o_underflow      pulse: pop rejected last cycle
//   o_err_sticky     sticky error flag
module fifo_umbral #(
  parameter int DATA_WIDTH = 6,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  input  logic                  i_pop,
  input  logic                  i_umbral_load,
  input  logic [DEPTH_LOG2:0]   i_umbral_af_in,
  input  logic [DEPTH_LOG2:0]   i_umbral_ae_in,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_data_valid,
  output logic                  o_fifo_full,
  output logic                  o_fifo_empty,
  output logic                  o_fifo_write,
  output logic                  o_fifo_read,
  output logic                  o_almost_full,
  output logic                  o_almost_empty,
  output logic                  o_umbral_set,
  output logic                  o_overflow,
  output logic                  o_underflow,
  output logic                  o_err_sticky
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_DEPTH  = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] C_AF_RST = C_DEPTH - 1'b1;
  localparam logic [DEPTH_LOG2:0] C_AE_RST = (DEPTH_LOG2+1)'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wptr;
  logic [DEPTH_LOG2-1:0] r_rptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic [DEPTH_LOG2:0]   r_af;
  logic [DEPTH_LOG2:0]   r_ae;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_data_valid;
  logic                  r_fifo_write;
  logic                  r_fifo_read;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_umbral_set;

  logic w_full;
  logic w_empty;
  logic w_pop_ok;
  logic w_push_ok;
  logic w_load_ok;

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // A pop on an empty FIFO is rejected even when a push arrives in the same
  // cycle; a push on a full FIFO is only allowed if a pop frees a slot.
  assign w_pop_ok  = i_pop && !w_empty;
  assign w_push_ok = i_push && (!w_full || w_pop_ok);

  assign w_load_ok = i_umbral_load && w_empty
                  && (i_umbral_af_in != '0)
                  && (i_umbral_af_in <= C_DEPTH)
                  && (i_umbral_ae_in < i_umbral_af_in);

  // Storage is intentionally not reset; pointers/count make it unreachable.
  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wptr] <= i_data_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_fifo_write <= 1'b0;
      r_fifo_read  <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop_ok) begin
        // Reads the old head even when a simultaneous push targets the same slot.
        r_rptr     <= r_rptr + 1'b1;
        r_data_out <= r_mem[r_rptr];
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      r_data_valid <= w_pop_ok;
      r_fifo_write <= w_push_ok;
      r_fifo_read  <= w_pop_ok;
      r_overflow   <= i_push && !w_push_ok;
      r_underflow  <= i_pop && !w_pop_ok;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_af         <= C_AF_RST;
      r_ae         <= C_AE_RST;
      r_umbral_set <= 1'b0;
    end else if (w_load_ok) begin
      r_af         <= i_umbral_af_in;
      r_ae         <= i_umbral_ae_in;
      r_umbral_set <= 1'b1;
    end
  end

`ifdef FIFO_ERR_STICKY_EN
  logic r_err_sticky;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err_sticky <= 1'b0;
    end else if ((i_push && !w_push_ok) || (i_pop && !w_pop_ok)) begin
      r_err_sticky <= 1'b1;
    end
  end

  assign o_err_sticky = r_err_sticky;
`else
  assign o_err_sticky = 1'b0;
`endif

  // Status flags depend only on registered state.
  assign o_fifo_full    = w_full;
  assign o_fifo_empty   = w_empty;
  assign o_almost_full  = (r_count >= r_af);
  assign o_almost_empty = (r_count <= r_ae);

  assign o_data_out   = r_data_out;
  assign o_data_valid = r_data_valid;
  assign o_fifo_write = r_fifo_write;
  assign o_fifo_read  = r_fifo_read;
  assign o_overflow   = r_overflow;
  assign o_underflow  = r_underflow;
  assign o_umbral_set = r_umbral_set;

endmodule

// File: tb/tb_fifo_umbral.sv
module tb_fifo_umbral;

  logic       clk;
  logic       rst_n;
  logic       push, pop, load;
  logic [5:0] din;
  logic [3:0] af_in, ae_in;
  logic [5:0] o_data_out;
  logic o_data_valid, o_fifo_full, o_fifo_empty, o_fifo_write, o_fifo_read;
  logic o_almost_full, o_almost_empty, o_umbral_set, o_overflow, o_underflow;
  logic o_err_sticky;

  int checks = 0;
  int failures = 0;

  fifo_umbral #(.DATA_WIDTH(6), .DEPTH_LOG2(3)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_push(push), .i_data_in(din), .i_pop(pop),
    .i_umbral_load(load), .i_umbral_af_in(af_in), .i_umbral_ae_in(ae_in),
    .o_data_out(o_data_out), .o_data_valid(o_data_valid),
    .o_fifo_full(o_fifo_full), .o_fifo_empty(o_fifo_empty),
    .o_fifo_write(o_fifo_write), .o_fifo_read(o_fifo_read),
    .o_almost_full(o_almost_full), .o_almost_empty(o_almost_empty),
    .o_umbral_set(o_umbral_set), .o_overflow(o_overflow),
    .o_underflow(o_underflow), .o_err_sticky(o_err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: a queue of words plus threshold values.
  int m_q[$];
  int m_af, m_ae, m_dout;
  bit m_set, m_dv, m_wr, m_rd, m_ovf, m_udf, m_err;

  function automatic void model_reset();
    m_q.delete();
    m_af = 7; m_ae = 1; m_dout = 0;
    m_set = 0; m_dv = 0; m_wr = 0; m_rd = 0; m_ovf = 0; m_udf = 0; m_err = 0;
  endfunction

  function automatic void model_step(bit p, int d, bit r, bit l, int a, int e);
    int sz;
    bit pop_ok, push_ok, load_ok;
    sz = m_q.size();
    pop_ok  = r && (sz > 0);
    push_ok = p && ((sz < 8) || pop_ok);
    load_ok = l && (sz == 0) && (a > 0) && (a <= 8) && (e < a);
    if (pop_ok) m_dout = m_q.pop_front();
    if (push_ok) m_q.push_back(d);
    m_dv = pop_ok; m_rd = pop_ok; m_wr = push_ok;
    m_ovf = p && !push_ok;
    m_udf = r && !pop_ok;
`ifdef FIFO_ERR_STICKY_EN
    if (m_ovf || m_udf) m_err = 1;
`endif
    if (load_ok) begin
      m_af = a; m_ae = e; m_set = 1;
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    int sz;
    sz = m_q.size();
    chk("data_out", o_data_out, m_dout);
    chk("data_valid", o_data_valid, m_dv);
    chk("fifo_full", o_fifo_full, sz == 8);
    chk("fifo_empty", o_fifo_empty, sz == 0);
    chk("fifo_write", o_fifo_write, m_wr);
    chk("fifo_read", o_fifo_read, m_rd);
    chk("almost_full", o_almost_full, sz >= m_af);
    chk("almost_empty", o_almost_empty, sz <= m_ae);
    chk("umbral_set", o_umbral_set, m_set);
    chk("overflow", o_overflow, m_ovf);
    chk("underflow", o_underflow, m_udf);
    chk("err_sticky", o_err_sticky, m_err);
  endtask

  // Drive one cycle of inputs (called just after a falling edge), clock it,
  // then compare at the next falling edge.
  task automatic step(input bit p, input logic [5:0] d, input bit r,
                      input bit l, input logic [3:0] a, input logic [3:0] e);
    push = p; din = d; pop = r; load = l; af_in = a; ae_in = e;
    @(posedge clk);
    model_step(p, int'(d), r, l, int'(a), int'(e));
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_values();
    chk("rst_data_out", o_data_out, 0);
    chk("rst_data_valid", o_data_valid, 0);
    chk("rst_full", o_fifo_full, 0);
    chk("rst_empty", o_fifo_empty, 1);
    chk("rst_write", o_fifo_write, 0);
    chk("rst_read", o_fifo_read, 0);
    chk("rst_almost_full", o_almost_full, 0);
    chk("rst_almost_empty", o_almost_empty, 1);
    chk("rst_umbral_set", o_umbral_set, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_underflow", o_underflow, 0);
    chk("rst_err_sticky", o_err_sticky, 0);
  endtask

  task automatic apply_reset();
    push = 0; pop = 0; load = 0; din = '0; af_in = '0; ae_in = '0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_values();
    model_reset();
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit p; logic [5:0] d; bit r; bit l; logic [3:0] a; logic [3:0] e;
    bit e_full, e_empty, e_af, e_ae, e_set, e_dv;
    logic [5:0] e_dout;
    bit e_ovf, e_udf;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t mk(bit p, logic [5:0] d, bit r, bit l, logic [3:0] a,
                              logic [3:0] e, bit fu, bit em, bit xaf, bit xae,
                              bit st, bit dv, logic [5:0] dout, bit ov, bit ud);
    vec_t v;
    v.p = p; v.d = d; v.r = r; v.l = l; v.a = a; v.e = e;
    v.e_full = fu; v.e_empty = em; v.e_af = xaf; v.e_ae = xae; v.e_set = st;
    v.e_dv = dv; v.e_dout = dout; v.e_ovf = ov; v.e_udf = ud;
    return v;
  endfunction

  initial begin
    int nw;
    push = 0; pop = 0; load = 0; din = '0; af_in = '0; ae_in = '0; rst_n = 1'b1;
    model_reset();

    // Threshold / fill / drain table.      p  d     r  l  af ae  fu em af ae st dv dout ov ud
    tbl[0]  = mk(0, 6'h00, 0, 1, 5, 2,  0, 1, 0, 1, 1, 0, 6'h00, 0, 0);
    tbl[1]  = mk(1, 6'h01, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 6'h00, 0, 0);
    tbl[2]  = mk(1, 6'h02, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 6'h00, 0, 0);
    tbl[3]  = mk(1, 6'h03, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 6'h00, 0, 0);
    tbl[4]  = mk(0, 6'h00, 0, 1, 6, 1,  0, 0, 0, 0, 1, 0, 6'h00, 0, 0);
    tbl[5]  = mk(1, 6'h04, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 6'h00, 0, 0);
    tbl[6]  = mk(1, 6'h05, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 6'h00, 0, 0);
    tbl[7]  = mk(1, 6'h06, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 6'h00, 0, 0);
    tbl[8]  = mk(1, 6'h07, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0, 6'h00, 0, 0);
    tbl[9]  = mk(1, 6'h08, 0, 0, 0, 0,  1, 0, 1, 0, 1, 0, 6'h00, 0, 0);
    tbl[10] = mk(1, 6'h3F, 0, 0, 0, 0,  1, 0, 1, 0, 1, 0, 6'h00, 1, 0);
    tbl[11] = mk(0, 6'h00, 1, 0, 0, 0,  0, 0, 1, 0, 1, 1, 6'h01, 0, 0);
    tbl[12] = mk(1, 6'h09, 1, 0, 0, 0,  0, 0, 1, 0, 1, 1, 6'h02, 0, 0);
    tbl[13] = mk(0, 6'h00, 1, 0, 0, 0,  0, 0, 1, 0, 1, 1, 6'h03, 0, 0);
    tbl[14] = mk(0, 6'h00, 1, 0, 0, 0,  0, 0, 1, 0, 1, 1, 6'h04, 0, 0);
    tbl[15] = mk(0, 6'h00, 1, 0, 0, 0,  0, 0, 0, 0, 1, 1, 6'h05, 0, 0);
    tbl[16] = mk(0, 6'h00, 1, 0, 0, 0,  0, 0, 0, 0, 1, 1, 6'h06, 0, 0);
    tbl[17] = mk(0, 6'h00, 1, 0, 0, 0,  0, 0, 0, 1, 1, 1, 6'h07, 0, 0);
    tbl[18] = mk(0, 6'h00, 1, 0, 0, 0,  0, 0, 0, 1, 1, 1, 6'h08, 0, 0);
    tbl[19] = mk(0, 6'h00, 1, 0, 0, 0,  0, 1, 0, 1, 1, 1, 6'h09, 0, 0);
    tbl[20] = mk(0, 6'h00, 1, 0, 0, 0,  0, 1, 0, 1, 1, 0, 6'h09, 0, 1);
    tbl[21] = mk(0, 6'h00, 0, 1, 4, 4,  0, 1, 0, 1, 1, 0, 6'h09, 0, 0);
    tbl[22] = mk(1, 6'h11, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 6'h09, 0, 0);
    tbl[23] = mk(1, 6'h12, 0, 0, 0, 0,  0, 0, 0, 1, 1, 0, 6'h09, 0, 0);
    tbl[24] = mk(1, 6'h13, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 6'h09, 0, 0);

    @(negedge clk);
    apply_reset();
    for (int i = 0; i < 25; i++) begin
      step(tbl[i].p, tbl[i].d, tbl[i].r, tbl[i].l, tbl[i].a, tbl[i].e);
      chk($sformatf("tbl%0d_full", i), o_fifo_full, tbl[i].e_full);
      chk($sformatf("tbl%0d_empty", i), o_fifo_empty, tbl[i].e_empty);
      chk($sformatf("tbl%0d_almost_full", i), o_almost_full, tbl[i].e_af);
      chk($sformatf("tbl%0d_almost_empty", i), o_almost_empty, tbl[i].e_ae);
      chk($sformatf("tbl%0d_umbral_set", i), o_umbral_set, tbl[i].e_set);
      chk($sformatf("tbl%0d_data_valid", i), o_data_valid, tbl[i].e_dv);
      chk($sformatf("tbl%0d_data_out", i), o_data_out, tbl[i].e_dout);
      chk($sformatf("tbl%0d_overflow", i), o_overflow, tbl[i].e_ovf);
      chk($sformatf("tbl%0d_underflow", i), o_underflow, tbl[i].e_udf);
    end

    // Invalid loads before any valid one, then af == DEPTH boundary.
    apply_reset();
    step(0, 0, 0, 1, 0, 0);
    chk("load_af0_ignored", o_umbral_set, 0);
    step(0, 0, 0, 1, 9, 1);
    chk("load_af9_ignored", o_umbral_set, 0);
    step(0, 0, 0, 1, 3, 3);
    chk("load_ae_eq_af_ignored", o_umbral_set, 0);
    step(0, 0, 0, 1, 8, 7);
    chk("load_af8_accepted", o_umbral_set, 1);
    for (int i = 0; i < 8; i++) begin
      step(1, 6'(i + 1), 0, 0, 0, 0);
      chk($sformatf("af8_almost_full_c%0d", i + 1), o_almost_full, (i == 7));
      chk($sformatf("ae7_almost_empty_c%0d", i + 1), o_almost_empty, (i < 7));
    end

    // Fill 0x01..0x08, count write pulses, drain, then pop+push on empty.
    apply_reset();
    nw = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 6'(i + 1), 0, 0, 0, 0);
      nw += int'(o_fifo_write);
      chk($sformatf("fill_almost_full_c%0d", i + 1), o_almost_full, (i >= 6));
    end
    chk("fill_write_pulses", nw, 8);
    chk("fill_full", o_fifo_full, 1);
    chk("fill_not_empty", o_fifo_empty, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 1, 0, 0, 0);
      chk($sformatf("drain_word%0d", i), o_data_out, i + 1);
    end
    chk("drain_empty", o_fifo_empty, 1);
    step(1, 6'h15, 1, 0, 0, 0);
    chk("udf_with_push_underflow", o_underflow, 1);
    chk("udf_with_push_no_valid", o_data_valid, 0);
    chk("udf_with_push_not_empty", o_fifo_empty, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("udf_follow_pop_data", o_data_out, 6'h15);
    chk("udf_follow_pop_valid", o_data_valid, 1);

    // Full FIFO with simultaneous push+pop, three complete pointer wraps.
    for (int i = 0; i < 8; i++) step(1, 6'(i + 8'h20), 0, 0, 0, 0);
    for (int i = 0; i < 24; i++) begin
      step(1, 6'h2A ^ 6'(i), 1, 0, 0, 0);
      chk($sformatf("wrap%0d_full", i), o_fifo_full, 1);
      chk($sformatf("wrap%0d_no_overflow", i), o_overflow, 0);
    end
`ifdef FIFO_ERR_STICKY_EN
    chk("err_sticky_held", o_err_sticky, 1);
`else
    chk("err_sticky_tied", o_err_sticky, 0);
`endif

    // Asynchronous reset mid-operation.
    push = 0; pop = 0; load = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      int pp, pr;
      bit ld;
      pp = (i / 100) % 2 == 0 ? 70 : 35;
      pr = 100 - pp;
      ld = ($urandom_range(0, 99) < 8);
      step(($urandom_range(0, 99) < pp), 6'($urandom_range(0, 63)),
           ($urandom_range(0, 99) < pr), ld,
           4'($urandom_range(0, 10)), 4'($urandom_range(0, 10)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
